// File: rtl/ntt_coe_loader_pkg.sv
// Shared constants and state encoding for the NTT coefficient loader and core control.
package ntt_coe_loader_pkg;

  localparam int unsigned LANES         = 8;
  localparam int unsigned LANE_W        = $clog2(LANES);
  localparam int unsigned COE_WIDTH_DEF = 35;
  localparam int unsigned N_COE_DEF     = 4096;
  localparam int unsigned ADDR_W_DEF    = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/ntt_coe_packer.sv
// Packs LANES serial coefficients into one bank word; a short final word is zero-padded.
module ntt_coe_packer
  import ntt_coe_loader_pkg::*;
#(
  parameter int unsigned COE_WIDTH = COE_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       beat_i,
  input  logic [COE_WIDTH-1:0]       data_i,
  input  logic                       last_i,
  output logic                       we_o,
  output logic [LANES*COE_WIDTH-1:0] word_o
);

  localparam int unsigned WORD_W = LANES * COE_WIDTH;

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] pack_q, pack_d, word_q;
  logic              we_q;
  logic              word_done;

  // Lane 0 starts from an all-zero word, which provides the padding for short words.
  always_comb begin
    pack_d = (lane_q == '0) ? '0 : pack_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        pack_d[k*COE_WIDTH +: COE_WIDTH] = data_i;
      end
    end
    word_done = beat_i && (last_i || (lane_q == LANE_W'(LANES - 1)));
    lane_d    = word_done ? '0 : lane_q + LANE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      pack_q <= '0;
      word_q <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= word_done;
      if (beat_i) begin
        lane_q <= lane_d;
        pack_q <= pack_d;
      end
      if (word_done) begin
        word_q <= pack_d;
      end
    end
  end

  assign we_o   = we_q;
  assign word_o = word_q;

endmodule

// File: rtl/ntt_coe_loader.sv
// Streams one polynomial into the left B-bank, then starts the NTT core and waits for it.
module ntt_coe_loader
  import ntt_coe_loader_pkg::*;
#(
  parameter int unsigned COE_WIDTH = COE_WIDTH_DEF,
  parameter int unsigned N_COE     = N_COE_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [COE_WIDTH-1:0]       s_data,
  input  logic                       s_last,
  output logic                       o_we_b_l,
  output logic [ADDR_W-1:0]          o_addr_b_l,
  output logic [LANES*COE_WIDTH-1:0] o_data_b_l,
  output logic                       ntt_start,
  input  logic                       ntt_done,
  output logic                       busy,
  output logic                       err_len
);

  localparam int unsigned       CNT_W     = $clog2(N_COE);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_COE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COE / LANES - 1);

  ld_state_e         state_q;
  logic              s_ready_q, busy_q, start_q, err_q;
  logic [CNT_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              beat, at_end, last_eff, pk_we;

  assign beat     = s_valid && s_ready_q;
  assign at_end   = (idx_q == LAST_IDX);
  assign last_eff = s_last || at_end;

  ntt_coe_packer #(
    .COE_WIDTH (COE_WIDTH)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .beat_i (beat),
    .data_i (s_data),
    .last_i (last_eff),
    .we_o   (pk_we),
    .word_o (o_data_b_l)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
    end else begin
      start_q <= 1'b0;
      // Address advances after each write but parks on the final word address.
      if (pk_we && (addr_q != LAST_ADDR)) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          s_ready_q <= 1'b1;
          if (beat) begin
            busy_q <= 1'b1;
            idx_q  <= idx_q + CNT_W'(1);
            if (state_q == ST_IDLE) begin
              err_q <= 1'b0;
            end
            if (last_eff) begin
              if (!(s_last && at_end)) begin
                err_q <= 1'b1;
              end
              s_ready_q <= 1'b0;
              state_q   <= ST_FLUSH;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_FLUSH: begin
          start_q <= 1'b1;
          state_q <= ST_START;
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ntt_done) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b1;
            idx_q     <= '0;
            addr_q    <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign o_we_b_l   = pk_we;
  assign o_addr_b_l = addr_q;
  assign ntt_start  = start_q;
  assign busy       = busy_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_ntt_coe_loader.sv
// Scoreboard bench for ntt_coe_loader: expected bank writes are queued as beats are driven.
module tb_ntt_coe_loader;

  localparam int unsigned CW = 35;
  localparam int unsigned NC = 4096;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8 * CW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [CW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          o_we_b_l;
  logic [AW-1:0] o_addr_b_l;
  logic [DW-1:0] o_data_b_l;
  logic          ntt_start;
  logic          ntt_done = 1'b0;
  logic          busy;
  logic          err_len;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  start_cnt = 0;
  int  start_cyc = 0;
  int  last_beat_cyc = 0;
  wr_t exp_q[$];

  ntt_coe_loader #(
    .COE_WIDTH (CW),
    .N_COE     (NC),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .o_we_b_l   (o_we_b_l),
    .o_addr_b_l (o_addr_b_l),
    .o_data_b_l (o_data_b_l),
    .ntt_start  (ntt_start),
    .ntt_done   (ntt_done),
    .busy       (busy),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pop and compare every bank write; record start pulses.
  always @(negedge clk) begin
    wr_t e;
    if (o_we_b_l === 1'b1) begin
      wr_cnt++;
      check("wr_expected", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", DW'(o_addr_b_l), DW'(e.addr));
        check("wr_data", o_data_b_l, e.data);
        check("wr_cyc", DW'(cyc), DW'(e.cyc));
      end
    end
    if (ntt_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, DW'(s_ready), DW'(0));
    check({tag, "_we"}, DW'(o_we_b_l), DW'(0));
    check({tag, "_addr"}, DW'(o_addr_b_l), DW'(0));
    check({tag, "_data"}, o_data_b_l, DW'(0));
    check({tag, "_start"}, DW'(ntt_start), DW'(0));
    check({tag, "_busy"}, DW'(busy), DW'(0));
    check({tag, "_err"}, DW'(err_len), DW'(0));
  endtask

  // Drive n beats of base+i; last_at<0 means no s_last; done_at/abort_at<0 disable those events.
  task automatic send(input int n, input int last_at, input logic [CW-1:0] base,
                      input bit toggle, input int done_at, input int abort_at);
    logic [DW-1:0] cur;
    int i, stall, lane;
    cur = '0;
    i = 0;
    stall = 0;
    while (i < n) begin
      @(negedge clk);
      if (i == abort_at) begin
        s_valid  = 1'b0;
        s_last   = 1'b0;
        ntt_done = 1'b0;
        rst      = 1'b1;
        return;
      end
      ntt_done = (i == done_at);
      s_valid  = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data   = base + CW'(i);
      s_last   = (i == last_at);
      if (s_valid && s_ready) begin
        lane = i % 8;
        if (lane == 0) cur = '0;
        cur[lane*CW +: CW] = s_data;
        if (lane == 7 || i == last_at || i == NC - 1)
          exp_q.push_back('{AW'(i / 8), cur, cyc + 1});
        last_beat_cyc = cyc;
        i++;
        stall = 0;
      end else if (!s_ready) begin
        stall++;
        if (stall > 50) begin
          check("ready_timeout", DW'(s_ready), DW'(1));
          i = n;
        end
      end
    end
    @(negedge clk);
    s_valid  = 1'b0;
    s_last   = 1'b0;
    ntt_done = 1'b0;
  endtask

  // Wait for the start pulse, check the wrap-up, hold s_valid in WAIT, then release with ntt_done.
  task automatic finish_poly(input int exp_wr, input bit exp_err, input int wr0,
                             input int st0, input int wait_cyc);
    int k, rdy;
    k = 0;
    while (start_cnt == st0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("start_seen", DW'(start_cnt - st0), DW'(1));
    check("start_lat", DW'(start_cyc - last_beat_cyc), DW'(2));
    check("wr_count", DW'(wr_cnt - wr0), DW'(exp_wr));
    check("err_len", DW'(err_len), DW'(exp_err));
    check("busy_wait", DW'(busy), DW'(1));
    rdy = 0;
    for (int c = 0; c < wait_cyc; c++) begin
      @(negedge clk);
      s_valid = 1'b1;
      if (s_ready) rdy++;
    end
    check("ready_in_wait", DW'(rdy), DW'(0));
    check("start_once", DW'(start_cnt - st0), DW'(1));
    @(negedge clk);
    s_valid  = 1'b0;
    ntt_done = 1'b1;
    @(negedge clk);
    ntt_done = 1'b0;
    check("busy_after_done", DW'(busy), DW'(0));
    check("ready_after_done", DW'(s_ready), DW'(1));
    check("queue_drained", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    int wr0, st0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Full stream, s_valid held high.
    wr0 = wr_cnt; st0 = start_cnt;
    send(NC, NC - 1, CW'(0), 1'b0, -1, -1);
    finish_poly(512, 1'b0, wr0, st0, 100);

    // Same length with pseudo-random valid gaps, loaded back-to-back from addr 0.
    wr0 = wr_cnt; st0 = start_cnt;
    send(NC, NC - 1, CW'(35'h4_0000_0000), 1'b1, -1, -1);
    finish_poly(512, 1'b0, wr0, st0, 3);

    // Early s_last at coefficient 10: second word zero-padded.
    wr0 = wr_cnt; st0 = start_cnt;
    send(11, 10, CW'(35'h7_0000_0100), 1'b0, -1, -1);
    finish_poly(2, 1'b1, wr0, st0, 3);

    // No s_last at all: final index acts as last and flags the length error.
    wr0 = wr_cnt; st0 = start_cnt;
    send(NC, -1, CW'(35'h1_2345_0000), 1'b0, -1, -1);
    finish_poly(512, 1'b1, wr0, st0, 3);

    // ntt_done during LOAD must be ignored; err_len clears on the first beat.
    wr0 = wr_cnt; st0 = start_cnt;
    send(NC, NC - 1, CW'(35'h2_0000_0000), 1'b0, 1000, -1);
    finish_poly(512, 1'b0, wr0, st0, 3);

    // Reset at coefficient 2000 aborts without a start pulse.
    st0 = start_cnt;
    send(NC, NC - 1, CW'(35'h3_0000_0000), 1'b0, -1, 2000);
    @(negedge clk);
    check_reset("abort");
    check("abort_queue", DW'(exp_q.size()), DW'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_start", DW'(start_cnt - st0), DW'(0));

    // Fresh full stream after the abort.
    wr0 = wr_cnt; st0 = start_cnt;
    send(NC, NC - 1, CW'(35'h5_5555_0000), 1'b0, -1, -1);
    finish_poly(512, 1'b0, wr0, st0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
